// File: rtl/btb_pkg.sv
// Shared BTB controller definitions: geometry defaults, FSM states and the
// update-queue entry layout.
package btb_pkg;

  localparam int unsigned BIT_ENTRY = 5;
  localparam int unsigned TAG_W     = 32 - 2 - BIT_ENTRY;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } btb_state_e;

  typedef struct packed {
    logic [BIT_ENTRY-1:0] index;
    logic [TAG_W-1:0]     tag;
    logic [31:0]          target;
  } upd_entry_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Two-entry update queue between the execute-stage update port and the BTB
// arrays; flush empties it and takes priority over a same-cycle push.
module btb_upd_fifo #(
  parameter type entry_t = btb_pkg::upd_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  input  logic       flush,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign do_push = push && (count_q != 2'd2);
  assign do_pop  = pop  && (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/btb_ctrl.sv
// Branch target buffer controller: fetch-stage lookup, queued execute-stage
// installs, and a one-entry-per-cycle invalidation sweep after reset/flush.
module btb_ctrl #(
  parameter int unsigned BIT_ENTRY = btb_pkg::BIT_ENTRY,
  parameter int unsigned TAG_W     = 32 - 2 - BIT_ENTRY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          fetch_pc,
  output logic                 hit,
  output logic [31:0]          pred_target,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [31:0]          upd_pc,
  input  logic [31:0]          upd_target,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic [BIT_ENTRY-1:0] arr_rindex,
  output logic                 arr_load,
  output logic [BIT_ENTRY-1:0] arr_windex,
  output logic [TAG_W-1:0]     arr_tag_din,
  output logic [31:0]          arr_tgt_din,
  output logic                 arr_valid_din,
  input  logic [TAG_W-1:0]     arr_tag_dout,
  input  logic [31:0]          arr_tgt_dout,
  input  logic                 arr_valid_dout
);

  import btb_pkg::*;

  typedef struct packed {
    logic [BIT_ENTRY-1:0] index;
    logic [TAG_W-1:0]     tag;
    logic [31:0]          target;
  } entry_t;

  btb_state_e           state_q, state_d;
  logic [BIT_ENTRY-1:0] cnt_q, cnt_d;

  entry_t     fifo_in, fifo_head;
  logic [1:0] fifo_count;
  logic       fifo_push, fifo_pop;
  logic       unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  // A flush in either state (re)starts the sweep from index 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SWEEP: begin
        if (flush_req) begin
          cnt_d = '0;
        end else if (cnt_q == '1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + BIT_ENTRY'(1);
        end
      end
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flush_busy = (state_q == ST_SWEEP);
  assign upd_ready  = (state_q == ST_IDLE) && (fifo_count != 2'd2);
  assign fifo_push  = upd_valid && upd_ready;
  assign fifo_pop   = (state_q == ST_IDLE) && (fifo_count != 2'd0);

  assign fifo_in.index  = upd_pc[BIT_ENTRY+1:2];
  assign fifo_in.tag    = upd_pc[31:BIT_ENTRY+2];
  assign fifo_in.target = upd_target;

  btb_upd_fifo #(
    .entry_t (entry_t)
  ) u_upd_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .flush     (flush_req),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    arr_load      = 1'b0;
    arr_windex    = '0;
    arr_tag_din   = '0;
    arr_tgt_din   = '0;
    arr_valid_din = 1'b0;
    if (state_q == ST_SWEEP) begin
      arr_load   = 1'b1;
      arr_windex = cnt_q;
    end else if (fifo_count != 2'd0) begin
      arr_load      = 1'b1;
      arr_windex    = fifo_head.index;
      arr_tag_din   = fifo_head.tag;
      arr_tgt_din   = fifo_head.target;
      arr_valid_din = 1'b1;
    end
  end

  assign arr_rindex  = fetch_pc[BIT_ENTRY+1:2];
  assign hit         = arr_valid_dout && (arr_tag_dout == fetch_pc[31:BIT_ENTRY+2])
                       && (state_q == ST_IDLE);
  assign pred_target = hit ? arr_tgt_dout : (fetch_pc + 32'd4);

endmodule

// File: tb/tb_btb_ctrl.sv
// Bench for btb_ctrl with a behavioural tag/target/valid array and a
// scoreboard of expected install writes.
module tb_btb_ctrl;

  localparam int BE  = 5;
  localparam int TW  = 25;
  localparam int NUM = 32;

  logic          clk, rst;
  logic [31:0]   fetch_pc, pred_target, upd_pc, upd_target, arr_tgt_din, arr_tgt_dout;
  logic          hit, upd_valid, upd_ready, flush_req, flush_busy;
  logic [BE-1:0] arr_rindex, arr_windex;
  logic          arr_load, arr_valid_din, arr_valid_dout;
  logic [TW-1:0] arr_tag_din, arr_tag_dout;

  btb_ctrl #(.BIT_ENTRY(BE), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .hit(hit), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_target(upd_target),
    .flush_req(flush_req), .flush_busy(flush_busy), .arr_rindex(arr_rindex),
    .arr_load(arr_load), .arr_windex(arr_windex), .arr_tag_din(arr_tag_din),
    .arr_tgt_din(arr_tgt_din), .arr_valid_din(arr_valid_din), .arr_tag_dout(arr_tag_dout),
    .arr_tgt_dout(arr_tgt_dout), .arr_valid_dout(arr_valid_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [TW-1:0] tag_mem   [NUM];
  logic [31:0]   tgt_mem   [NUM];
  logic          valid_mem [NUM];

  always @(posedge clk) begin
    if (arr_load) begin
      tag_mem[arr_windex]   <= arr_tag_din;
      tgt_mem[arr_windex]   <= arr_tgt_din;
      valid_mem[arr_windex] <= arr_valid_din;
    end
  end

  always_comb begin
    arr_tag_dout   = tag_mem[arr_rindex];
    arr_tgt_dout   = tgt_mem[arr_rindex];
    arr_valid_dout = valid_mem[arr_rindex];
    if (arr_load && arr_windex == arr_rindex) begin
      arr_tag_dout   = arr_tag_din;
      arr_tgt_dout   = arr_tgt_din;
      arr_valid_dout = arr_valid_din;
    end
  end

  typedef struct {
    logic [BE-1:0] idx;
    logic [TW-1:0] tag;
    logic [31:0]   tgt;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   total = 0;
  int   bad   = 0;

  // Install writes are the only array writes with valid_din=1.
  always @(negedge clk) begin
    if (rst && arr_load && arr_valid_din) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write: got idx=%0d tag=%h tgt=%h, expected no write",
                 arr_windex, arr_tag_din, arr_tgt_din);
      end else begin
        got = sb.pop_front();
        if ({arr_windex, arr_tag_din, arr_tgt_din} !== {got.idx, got.tag, got.tgt}) begin
          bad++;
          $display("FAIL sb_write: got idx=%0d tag=%h tgt=%h, expected idx=%0d tag=%h tgt=%h",
                   arr_windex, arr_tag_din, arr_tgt_din, got.idx, got.tag, got.tgt);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({flush_busy, upd_ready, hit, arr_windex} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      bad++;
      $display("FAIL reset_state: got busy=%b ready=%b hit=%b widx=%0d, expected 1 0 0 0",
               flush_busy, upd_ready, hit, arr_windex);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (arr_windex !== 5'(i)) begin
        bad++;
        $display("FAIL partial_sweep: got widx=%0d, expected %0d", arr_windex, i);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    total++;
    if (arr_windex !== 5'd0 || flush_busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_sweep_reset: got widx=%0d busy=%b, expected 0 1", arr_windex, flush_busy);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      total++;
      if (flush_busy !== 1'b1 || arr_load !== 1'b1 || arr_windex !== 5'(i) || arr_valid_din !== 1'b0) begin
        bad++;
        $display("FAIL sweep_step: got busy=%b load=%b widx=%0d vdin=%b, expected 1 1 %0d 0",
                 flush_busy, arr_load, arr_windex, arr_valid_din, i);
      end
      @(negedge clk);
    end
    total++;
    if ({flush_busy, upd_ready, arr_load} !== 3'b010) begin
      bad++;
      $display("FAIL sweep_end: got busy=%b ready=%b load=%b, expected 0 1 0",
               flush_busy, upd_ready, arr_load);
    end
  endtask

  task automatic test_hit;
    upd_valid = 1'b1; upd_pc = 32'h0000_0040; upd_target = 32'h0000_1000;
    total++;
    if (upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL hit_accept: got ready=%b, expected 1", upd_ready);
    end
    sb.push_back('{idx: upd_pc[6:2], tag: upd_pc[31:7], tgt: upd_target});
    @(negedge clk);
    upd_valid = 1'b0;
    @(negedge clk);
    fetch_pc = 32'h0000_0040;
    #1;
    total++;
    if (hit !== 1'b1 || pred_target !== 32'h0000_1000) begin
      bad++;
      $display("FAIL lookup_hit: got hit=%b pred=%h, expected 1 00001000", hit, pred_target);
    end
    fetch_pc = 32'h0000_0840;
    #1;
    total++;
    if (hit !== 1'b0 || pred_target !== 32'h0000_0844) begin
      bad++;
      $display("FAIL lookup_tag_miss: got hit=%b pred=%h, expected 0 00000844", hit, pred_target);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    fetch_pc = 32'hFFFF_FFFC;
    #1;
    total++;
    if (hit !== 1'b0 || pred_target !== 32'h0000_0000) begin
      bad++;
      $display("FAIL pc_wrap: got hit=%b pred=%h, expected 0 00000000", hit, pred_target);
    end
    fetch_pc = 32'h0000_1234;
    #1;
    total++;
    if (hit !== 1'b0 || pred_target !== 32'h0000_1238) begin
      bad++;
      $display("FAIL plain_miss: got hit=%b pred=%h, expected 0 00001238", hit, pred_target);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_restart;
    int busy = 0;
    int expidx = 0;
    bit restarted = 1'b0;
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    for (int c = 0; c < 200 && flush_busy; c++) begin
      total++;
      if (arr_windex !== 5'(expidx)) begin
        bad++;
        $display("FAIL restart_index: got widx=%0d, expected %0d", arr_windex, expidx);
      end
      busy++;
      if (!restarted && expidx == 10) begin
        flush_req = 1'b1;
        restarted = 1'b1;
        expidx = 0;
      end else begin
        expidx++;
      end
      @(negedge clk);
      flush_req = 1'b0;
    end
    total++;
    if (busy != 43 || flush_busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_length: got busy_cycles=%0d busy=%b, expected 43 0", busy, flush_busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pcs  [3];
    logic [31:0] tgts [3];
    int k = 0;
    pcs  = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    tgts = '{32'h0000_2000, 32'h0000_2004, 32'h0000_2008};
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    upd_valid = 1'b1; upd_pc = pcs[0]; upd_target = tgts[0];
    for (int c = 0; c < 200 && k < 3; c++) begin
      if (flush_busy) begin
        total++;
        if (upd_ready !== 1'b0) begin
          bad++;
          $display("FAIL b2b_ready_in_sweep: got ready=%b, expected 0", upd_ready);
        end
      end else if (upd_ready) begin
        total++;
        if (arr_load !== (k > 0)) begin
          bad++;
          $display("FAIL b2b_write_cadence: got load=%b, expected %0d at accept %0d", arr_load, k > 0, k);
        end
        sb.push_back('{idx: upd_pc[6:2], tag: upd_pc[31:7], tgt: upd_target});
        k++;
      end
      @(negedge clk);
      if (k < 3) begin
        upd_pc = pcs[k]; upd_target = tgts[k];
      end else begin
        upd_valid = 1'b0;
      end
    end
    total++;
    if (k != 3) begin
      bad++;
      $display("FAIL b2b_timeout: got accepted=%0d, expected 3", k);
    end
    total++;
    if (arr_load !== 1'b1) begin
      bad++;
      $display("FAIL b2b_last_write: got load=%b, expected 1", arr_load);
    end
    @(negedge clk);
    total++;
    if (arr_load !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drained: got load=%b, expected 0", arr_load);
    end
    fetch_pc = 32'h0000_0104;
    #1;
    total++;
    if (hit !== 1'b1 || pred_target !== 32'h0000_2004) begin
      bad++;
      $display("FAIL b2b_lookup: got hit=%b pred=%h, expected 1 00002004", hit, pred_target);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_discard;
    upd_valid = 1'b1; upd_pc = 32'h0000_0200; upd_target = 32'h0000_3000;
    total++;
    if (upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL discard_accept1: got ready=%b, expected 1", upd_ready);
    end
    sb.push_back('{idx: upd_pc[6:2], tag: upd_pc[31:7], tgt: upd_target});
    @(negedge clk);
    upd_pc = 32'h0000_0204; upd_target = 32'h0000_3004; flush_req = 1'b1;
    total++;
    if (upd_ready !== 1'b1) begin
      bad++;
      $display("FAIL discard_accept2: got ready=%b, expected 1", upd_ready);
    end
    @(negedge clk);
    upd_valid = 1'b0; flush_req = 1'b0;
    total++;
    if (flush_busy !== 1'b1) begin
      bad++;
      $display("FAIL discard_busy: got busy=%b, expected 1", flush_busy);
    end
    for (int c = 0; c < 100 && flush_busy; c++) @(negedge clk);
    total++;
    if (flush_busy !== 1'b0 || arr_load !== 1'b0) begin
      bad++;
      $display("FAIL discard_fifo_empty: got busy=%b load=%b, expected 0 0", flush_busy, arr_load);
    end
    fetch_pc = 32'h0000_0200;
    #1;
    total++;
    if (hit !== 1'b0 || pred_target !== 32'h0000_0204) begin
      bad++;
      $display("FAIL discard_lookup1: got hit=%b pred=%h, expected 0 00000204", hit, pred_target);
    end
    fetch_pc = 32'h0000_0204;
    #1;
    total++;
    if (hit !== 1'b0 || pred_target !== 32'h0000_0208) begin
      bad++;
      $display("FAIL discard_lookup2: got hit=%b pred=%h, expected 0 00000208", hit, pred_target);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_target = '0; flush_req = 1'b0;
    test_reset();
    test_hit();
    test_wrap();
    test_flush_restart();
    test_back_to_back();
    test_flush_discard();
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: got %0d pending writes, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btb_ctrl.md
BTB_CTRL -- requirements
Module: btb_ctrl

Interface
REQ-001 Parameter BIT_ENTRY, default 5, log2 of BTB entry count; NUM_ENTRY = 2**BIT_ENTRY.
REQ-002 Parameter TAG_W, default 32-2-BIT_ENTRY, tag width taken from pc[31:BIT_ENTRY+2].
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 fetch_pc  in  32  fetch-stage lookup PC.
REQ-006 hit  out  1  lookup hit for fetch_pc.
REQ-007 pred_target  out  32  predicted next PC.
REQ-008 upd_valid  in  1  execute-stage update request.
REQ-009 upd_ready  out  1  update request accepted when upd_valid and upd_ready are both 1 at the clock edge.
REQ-010 upd_pc  in  32  branch PC to install.
REQ-011 upd_target  in  32  taken target to install.
REQ-012 flush_req  in  1  single-cycle pulse requesting invalidation of every entry.
REQ-013 flush_busy  out  1  invalidation sweep in progress.
REQ-014 arr_rindex  out  BIT_ENTRY  read index to the tag, target and valid arrays.
REQ-015 arr_load, arr_windex  out  1 / BIT_ENTRY  common write enable and write index.
REQ-016 arr_tag_din, arr_tgt_din, arr_valid_din  out  TAG_W / 32 / 1  write data.
REQ-017 arr_tag_dout, arr_tgt_dout, arr_valid_dout  in  TAG_W / 32 / 1  read data, combinational from arr_rindex, write-forwarded when indices match.

Function
REQ-018 arr_rindex SHALL equal fetch_pc[BIT_ENTRY+1:2] combinationally.
REQ-019 hit SHALL be 1 only when arr_valid_dout is 1, arr_tag_dout equals fetch_pc[31:BIT_ENTRY+2], and state is IDLE.
REQ-020 pred_target SHALL be arr_tgt_dout when hit is 1, otherwise fetch_pc+4 modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
REQ-021 Accepted updates SHALL enter a 2-deep FIFO holding index, tag and target; upd_ready = (count<2) and state==IDLE, derived from registered state only.
REQ-022 In IDLE with FIFO non-empty, the block SHALL drive arr_load=1 with the head entry and arr_valid_din=1, and pop the head in the same cycle; latency from accept to array write is one cycle when the FIFO is empty.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 FSM states: SWEEP, IDLE. SWEEP->IDLE when sweep counter == NUM_ENTRY-1; IDLE->SWEEP on flush_req.
REQ-025 In SWEEP, each cycle the block SHALL write arr_load=1, arr_windex=counter, all data 0, and increment the counter; a full sweep takes exactly NUM_ENTRY cycles.
REQ-026 Entering SWEEP SHALL clear the FIFO and discard its contents; no update write occurs during SWEEP.
REQ-027 flush_req asserted during SWEEP SHALL restart the counter at 0.
REQ-028 flush_busy SHALL equal (state==SWEEP).
REQ-029 arr_load SHALL be 0 in IDLE when the FIFO is empty.

Reset
REQ-030 While rst=0: state=SWEEP, counter=0, FIFO count=0; outputs flush_busy=1, upd_ready=0, hit=0.
REQ-031 After reset release, the block SHALL perform one full sweep before entering IDLE; reset asserted mid-sweep SHALL restart the sweep from index 0.

Structure
REQ-032 Package btb_pkg SHALL hold BIT_ENTRY, TAG_W, the state enum, and the packed update-entry struct (index, tag, target).
REQ-033 The FIFO SHALL be a sub-module btb_upd_fifo (depth 2, push/pop/flush/count).

Verification
REQ-034 Reset release: flush_busy=1 for exactly 32 cycles, arr_windex steps 0..31 with arr_load=1, then upd_ready=1.
REQ-035 Update upd_pc=0x00000040, upd_target=0x00001000, then fetch_pc=0x00000040 -> hit=1, pred_target=0x00001000; fetch_pc=0x00000840 (same index, different tag) -> hit=0, pred_target=0x00000844.
REQ-036 Three back-to-back updates while the array is blocked by a sweep -> upd_ready=0 throughout; updates issued after the sweep are written in order, one per cycle.
REQ-037 flush_req at sweep counter 10 -> counter returns to 0, total busy length = 11+32 cycles.
REQ-038 Queue 2 updates, then pulse flush_req -> both discarded; lookup of either PC after the sweep -> hit=0.
REQ-039 fetch_pc=0xFFFFFFFC on a miss -> pred_target=0x00000000.
